// File: rtl/store_merge_pkg.sv
// Shared size/state encodings and lane helpers for the store merge unit.
package store_merge_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WAIT = 3'd2,
    WR   = 3'd3,
    ERR  = 3'd4
  } state_e;

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      SZ_BYTE: m = 4'b0001 << off;
      SZ_HALF: m = off[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Places the low byte/half of the register value into every lane it could land in.
  function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] r;
    case (size)
      SZ_BYTE: r = {4{data[7:0]}};
      SZ_HALF: r = {2{data[15:0]}};
      default: r = data;
    endcase
    return r;
  endfunction

  function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/store_merge_unit_lane_merge.sv
// Per-lane select between an old memory word and new data under a byte mask.
module byte_lane_merge (
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  input  logic [3:0]  mask,
  output logic [31:0] merged
);

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign merged[8*i +: 8] = mask[i] ? new_data[8*i +: 8] : old_word[8*i +: 8];
  end

endmodule

// File: rtl/store_merge_unit.sv
// Narrows a register value to byte/half/word and writes it to word-addressed memory.
// Build option STORE_BYTE_STROBE_EN: byte enables replace read-modify-write.
//
// state | meaning
// IDLE  | ready, waiting for a store request
// RD    | one-cycle memory read of the target word
// WAIT  | counting read latency, sample read data on terminal count
// WR    | write merged word, signal done
// ERR   | illegal size or misaligned address, signal done with error
module store_merge_unit
  import store_merge_pkg::*;
#(
  parameter int MEM_RD_LAT = 1,
  parameter int ADDR_W     = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  input  logic [1:0]        size_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rd_o,
  input  logic [31:0]       mem_rdata_i,
  output logic              mem_wr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              done_o,
  output logic              err_o
`ifdef STORE_BYTE_STROBE_EN
  ,
  output logic [3:0]        mem_be_o
`endif
);

  localparam logic [1:0] LAT_LOAD = 2'(MEM_RD_LAT - 1);

  state_e      state_q;
  logic [31:0] data_q;
  logic [3:0]  mask_q;
  logic [1:0]  cnt_q;

  logic        accept;
  logic [3:0]  req_mask;
  logic [31:0] req_data;
  logic        req_bad;
  logic [31:0] merge_old;
  logic [31:0] merge_new;
  logic [3:0]  merge_mask;
  logic [31:0] merged;

  assign accept   = req_valid_i & req_ready_o;
  assign req_mask = lane_mask(size_i, addr_i[1:0]);
  assign req_data = replicate(size_i, wdata_i);
  assign req_bad  = is_illegal(size_i, addr_i[1:0]);

`ifdef STORE_BYTE_STROBE_EN
  // Untargeted lanes are driven to zero; the byte enables keep memory intact.
  assign merge_old  = '0;
  assign merge_new  = req_data;
  assign merge_mask = req_mask;
`else
  assign merge_old  = mem_rdata_i;
  assign merge_new  = data_q;
  assign merge_mask = mask_q;
`endif

  byte_lane_merge u_merge (
    .old_word (merge_old),
    .new_data (merge_new),
    .mask     (merge_mask),
    .merged   (merged)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      req_ready_o <= 1'b1;
      mem_addr_o  <= '0;
      mem_rd_o    <= 1'b0;
      mem_wr_o    <= 1'b0;
      mem_wdata_o <= '0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      data_q      <= '0;
      mask_q      <= '0;
      cnt_q       <= '0;
`ifdef STORE_BYTE_STROBE_EN
      mem_be_o    <= '0;
`endif
    end else begin
      mem_rd_o    <= 1'b0;
      mem_wr_o    <= 1'b0;
      mem_wdata_o <= '0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
`ifdef STORE_BYTE_STROBE_EN
      mem_be_o    <= '0;
`endif
      case (state_q)
        IDLE: begin
          if (accept) begin
            req_ready_o <= 1'b0;
            data_q      <= req_data;
            mask_q      <= req_mask;
            if (req_bad) begin
              state_q <= ERR;
              err_o   <= 1'b1;
              done_o  <= 1'b1;
            end else begin
              mem_addr_o <= {addr_i[ADDR_W-1:2], 2'b00};
              if (size_i == SZ_WORD) begin
                state_q     <= WR;
                mem_wr_o    <= 1'b1;
                done_o      <= 1'b1;
                mem_wdata_o <= wdata_i;
`ifdef STORE_BYTE_STROBE_EN
                mem_be_o    <= 4'b1111;
`endif
              end else begin
`ifdef STORE_BYTE_STROBE_EN
                state_q     <= WR;
                mem_wr_o    <= 1'b1;
                done_o      <= 1'b1;
                mem_wdata_o <= merged;
                mem_be_o    <= req_mask;
`else
                state_q  <= RD;
                mem_rd_o <= 1'b1;
`endif
              end
            end
          end
        end
        RD: begin
          state_q <= WAIT;
          cnt_q   <= LAT_LOAD;
        end
        WAIT: begin
          // Read data is only looked at on terminal count.
          if (cnt_q == 2'd0) begin
            state_q     <= WR;
            mem_wr_o    <= 1'b1;
            done_o      <= 1'b1;
            mem_wdata_o <= merged;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        WR, ERR: begin
          state_q     <= IDLE;
          req_ready_o <= 1'b1;
        end
        default: begin
          state_q     <= IDLE;
          req_ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_merge_unit.sv
// Scoreboard bench for store_merge_unit: random stores against a byte-level memory model.
module tb_store_merge_unit;

  localparam int LAT  = 1;
  localparam int LAT3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req_valid, req_ready, mem_rd, mem_wr, done, err;
  logic [31:0] addr, wdata, mem_addr, mem_rdata, mem_wdata;
  logic [1:0]  size;

  logic        rst3, valid3, ready3, mrd3, mwr3, done3, err3;
  logic [31:0] addr3, wdata3, maddr3, rdata3, mwdata3;
  logic [1:0]  size3;

  store_merge_unit #(.MEM_RD_LAT(LAT), .ADDR_W(32)) u_dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .addr_i(addr), .wdata_i(wdata), .size_i(size), .mem_addr_o(mem_addr),
    .mem_rd_o(mem_rd), .mem_rdata_i(mem_rdata), .mem_wr_o(mem_wr),
    .mem_wdata_o(mem_wdata), .done_o(done), .err_o(err)
  );

  store_merge_unit #(.MEM_RD_LAT(LAT3), .ADDR_W(32)) u_dut3 (
    .clk_i(clk), .rst_i(rst3), .req_valid_i(valid3), .req_ready_o(ready3),
    .addr_i(addr3), .wdata_i(wdata3), .size_i(size3), .mem_addr_o(maddr3),
    .mem_rd_o(mrd3), .mem_rdata_i(rdata3), .mem_wr_o(mwr3),
    .mem_wdata_o(mwdata3), .done_o(done3), .err_o(err3)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, expv);
    end
  endtask

  // Memory seen by the DUT (updated by its writes) and the reference copy.
  logic [31:0] sim_mem [16];
  logic [31:0] ref_mem [16];

  typedef struct {
    logic        is_err;
    logic        sub;
    logic [31:0] waddr;
    logic [31:0] wword;
    int          acc;
    int          lat;
  } exp_t;
  exp_t q[$];

  int          rd_cd = 0;
  logic [31:0] rd_addr_l = '0;
  always @(negedge clk) begin
    if (rd_cd == 1) mem_rdata = sim_mem[rd_addr_l[5:2]];
    else            mem_rdata = $urandom;
    if (rd_cd > 0) rd_cd--;
    if (mem_rd) begin rd_cd = LAT; rd_addr_l = mem_addr; end
    if (mem_wr) sim_mem[mem_addr[5:2]] = mem_wdata;
  end

  int          rd_seen = 0;
  logic [31:0] rd_seen_addr = '0;
  logic        prev_done = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (mem_rd) begin rd_seen++; rd_seen_addr = mem_addr; end
      if (!mem_wr) chk("wdata_idle_zero", mem_wdata, 32'h0);
      if (mem_wr && !done) chk("wr_without_done", {31'b0, done}, 32'h1);
      if (err && !done) chk("err_without_done", {31'b0, done}, 32'h1);
      if (q.size() > 0) chk("ready_low_busy", {31'b0, req_ready}, 32'h0);
      if (prev_done) chk("ready_after_done", {31'b0, req_ready}, 32'h1);
      if (done) begin
        if (q.size() == 0) chk("unexpected_done", 32'h1, 32'h0);
        else begin
          e = q.pop_front();
          chk("latency", cyc - e.acc, e.lat);
          chk("err", {31'b0, err}, {31'b0, e.is_err});
          chk("wr", {31'b0, mem_wr}, {31'b0, !e.is_err});
          chk("rd_count", rd_seen, e.sub ? 32'd1 : 32'd0);
          if (e.sub) chk("rd_addr", rd_seen_addr, e.waddr);
          if (!e.is_err) begin
            chk("wr_addr", mem_addr, e.waddr);
            chk("wr_data", mem_wdata, e.wword);
          end
        end
        rd_seen = 0;
      end
      prev_done = done;
    end
  end

  // Second instance: single backing word at 0x100, latency LAT3.
  int cd3 = 0;
  int wr3_count = 0;
  always @(negedge clk) begin
    if (cd3 == 1) rdata3 = 32'h11223344;
    else          rdata3 = $urandom;
    if (cd3 > 0) cd3--;
    if (mrd3) cd3 = LAT3;
    if (mwr3) wr3_count++;
  end

  task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                        input int gap);
    exp_t        e;
    logic [1:0]  off;
    logic [31:0] nw;
    int          n;
    int          k;
    repeat (gap) begin @(negedge clk); req_valid = 1'b0; end
    @(negedge clk);
    req_valid = 1'b1; addr = a; wdata = d; size = s;
    n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    if (!req_ready) begin
      chk("accept_timeout", 32'h1, 32'h0);
      req_valid = 1'b0;
      return;
    end
    k   = cyc;
    off = a[1:0];
    e.is_err = (s == 2'd3) || (s == 2'd1 && off[0]) || (s == 2'd2 && off != 2'd0);
    e.sub    = !e.is_err && (s != 2'd2);
    e.waddr  = {a[31:2], 2'b00};
    nw = ref_mem[a[5:2]];
    if (s == 2'd0) nw[8*off +: 8]  = d[7:0];
    if (s == 2'd1) nw[8*off +: 16] = d[15:0];
    if (s == 2'd2) nw = d;
    e.wword = nw;
    if (!e.is_err) ref_mem[a[5:2]] = nw;
    e.lat = e.sub ? 2 + LAT : 1;
    e.acc = k;
    @(posedge clk);
    q.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    req_valid = 1'b0;
    while (q.size() > 0 && n < 200) begin @(negedge clk); n++; end
    if (q.size() > 0) begin
      chk("drain_timeout", q.size(), 32'h0);
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    sim_mem[a[5:2]] = v;
    ref_mem[a[5:2]] = v;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, n, wr_before;
    logic [31:0] ra;
    rst = 1'b1; req_valid = 1'b0; addr = '0; wdata = '0; size = '0;
    rst3 = 1'b1; valid3 = 1'b0; addr3 = '0; wdata3 = '0; size3 = '0;
    for (int i = 0; i < 16; i++) begin
      sim_mem[i] = $urandom;
      ref_mem[i] = sim_mem[i];
    end
    #2;
    chk("rst_ready", {31'b0, req_ready}, 32'h1);
    chk("rst_rd", {31'b0, mem_rd}, 32'h0);
    chk("rst_wr", {31'b0, mem_wr}, 32'h0);
    chk("rst_done_err", {30'b0, done, err}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0; rst3 = 1'b0;

    preload(32'h100, 32'h11223344);
    do_req(32'h102, 32'h000000AB, 2'd0, 0);
    wait_idle();
    chk("tp_byte_mem", sim_mem[0], 32'h11AB3344);
    preload(32'h100, 32'h11223344);
    do_req(32'h102, 32'hFFFFBEEF, 2'd1, 0);
    wait_idle();
    chk("tp_half_hi_mem", sim_mem[0], 32'hBEEF3344);
    preload(32'h100, 32'h11223344);
    do_req(32'h100, 32'h00005566, 2'd1, 0);
    wait_idle();
    chk("tp_half_lo_mem", sim_mem[0], 32'h11225566);
    do_req(32'h104, 32'hDEADBEEF, 2'd2, 0);
    wait_idle();
    chk("tp_word_mem", sim_mem[1], 32'hDEADBEEF);
    do_req(32'h101, 32'h12345678, 2'd1, 0);
    do_req(32'h108, 32'h12345678, 2'd3, 0);
    do_req(32'h100, 32'h000000C3, 2'd0, 0);
    do_req(32'h104, 32'hCAFEF00D, 2'd2, 0);
    do_req(32'h10A, 32'h00009A9A, 2'd1, 0);
    wait_idle();

    for (int i = 0; i < 200; i++) begin
      ra = 32'h100 + $urandom_range(0, 63);
      do_req(ra, $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 2));
    end
    wait_idle();

    // Latency 3 instance: normal byte store, then reset during WAIT.
    @(negedge clk);
    valid3 = 1'b1; addr3 = 32'h103; wdata3 = 32'h000000AB; size3 = 2'd0;
    k = cyc;
    @(negedge clk);
    valid3 = 1'b0;
    chk("l3_rd_pulse", {31'b0, mrd3}, 32'h1);
    chk("l3_rd_addr", maddr3, 32'h100);
    n = 0;
    while (!done3 && n < 20) begin @(negedge clk); n++; end
    chk("l3_latency", cyc - k, 2 + LAT3);
    chk("l3_wdata", mwdata3, 32'hAB223344);
    @(negedge clk);
    valid3 = 1'b1; addr3 = 32'h103; wdata3 = 32'h00000055; size3 = 2'd0;
    @(negedge clk);
    valid3 = 1'b0;
    @(negedge clk);
    chk("l3_busy_ready", {31'b0, ready3}, 32'h0);
    wr_before = wr3_count;
    #1 rst3 = 1'b1;
    #1;
    chk("l3_rst_outs", {27'b0, mrd3, mwr3, done3, err3, ready3}, 32'h1);
    chk("l3_rst_wdata", mwdata3, 32'h0);
    chk("l3_rst_addr", maddr3, 32'h0);
    @(negedge clk);
    rst3 = 1'b0;
    repeat (10) @(negedge clk);
    chk("l3_no_wr_after_rst", wr3_count, wr_before);
    chk("l3_ready_after_rst", {31'b0, ready3}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
